// File: rtl/data_mem_responder.sv
// Byte-wide data memory responder: accepts one request at a time, completes it
// after LATENCY cycles, and reports completion with a single-cycle resp_valid.
module data_mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int DEPTH   = 16384,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [7:0]        resp_rdata,
    output logic [23:0]       resp_rdata_ext,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [7:0]        cap_wdata;
    logic              complete;

    logic [7:0] mem [DEPTH];

    assign req_ready      = (state == IDLE);
    assign busy           = (state == ACCESS);
    assign complete       = (state == ACCESS) && (cnt == 4'd0);
    assign resp_rdata_ext = {16'b0, resp_rdata};

    // Contents survive reset; a reset mid-access forces IDLE, so complete
    // stays low and an aborted write never lands.
    always_ff @(posedge clk) begin
        if (complete && cap_we) begin
            mem[cap_addr] <= cap_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= 8'h00;
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_rdata <= 8'h00;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // resp_rdata keeps the last read byte across write completions
                        resp_valid <= 1'b1;
                        resp_we    <= cap_we;
                        if (!cap_we) begin
                            resp_rdata <= mem[cap_addr];
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder: a LATENCY=2 instance
// for the main tests and a LATENCY=1 instance for the back-to-back case.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;

    logic        req_valid;
    logic        req_we;
    logic [13:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_we;
    logic [7:0]  resp_rdata;
    logic [23:0] resp_rdata_ext;
    logic        busy;

    logic        r1_valid;
    logic        r1_we;
    logic [13:0] r1_addr;
    logic [7:0]  r1_wdata;
    logic        r1_ready;
    logic        r1_resp_valid;
    logic        r1_resp_we;
    logic [7:0]  r1_rdata;
    logic [23:0] r1_rdata_ext;
    logic        r1_busy;

    int errors;
    int checks;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        string       name;
    } vec_t;

    vec_t vecs[10];

    data_mem_responder #(.ADDR_W(14), .DEPTH(16384), .LATENCY(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_we        (resp_we),
        .resp_rdata     (resp_rdata),
        .resp_rdata_ext (resp_rdata_ext),
        .busy           (busy)
    );

    data_mem_responder #(.ADDR_W(14), .DEPTH(16384), .LATENCY(1)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (r1_valid),
        .req_we         (r1_we),
        .req_addr       (r1_addr),
        .req_wdata      (r1_wdata),
        .req_ready      (r1_ready),
        .resp_valid     (r1_resp_valid),
        .resp_we        (r1_resp_we),
        .resp_rdata     (r1_rdata),
        .resp_rdata_ext (r1_rdata_ext),
        .busy           (r1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One full access on the LATENCY=2 instance, scrambling inputs right after
    // acceptance so the in-flight access must rely on its captured copy.
    task automatic applyStimulus(input logic we, input logic [13:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] exp_rdata, input string name);
        int lat;
        lat = -1;
        @(negedge clk);
        checkOutput({name, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n - 1;
                break;
            end
        end
        checkOutput({name, " latency"}, 32'(lat), 32'd2);
        checkOutput({name, " resp_we"}, 32'(resp_we), 32'(we));
        checkOutput({name, " rdata"}, 32'(resp_rdata), 32'(exp_rdata));
        checkOutput({name, " rdata_ext"}, 32'(resp_rdata_ext), {16'h0, 8'h00, exp_rdata});
        checkOutput({name, " ready_in_resp"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        checkOutput({name, " pulse_end"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [13:0] bd_addr [9];
        int pulses;

        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = 8'h00;
        r1_valid  = 1'b0;
        r1_we     = 1'b0;
        r1_addr   = '0;
        r1_wdata  = 8'h00;

        vecs[0] = '{1'b1, 14'h0010, 8'hA5, 8'h00, "wr_0010"};
        vecs[1] = '{1'b0, 14'h0010, 8'h00, 8'hA5, "rd_0010"};
        vecs[2] = '{1'b1, 14'h3FFF, 8'hFF, 8'hA5, "wr_3fff"};
        vecs[3] = '{1'b1, 14'h0000, 8'h01, 8'hA5, "wr_0000"};
        vecs[4] = '{1'b0, 14'h3FFF, 8'h00, 8'hFF, "rd_3fff"};
        vecs[5] = '{1'b0, 14'h0000, 8'h00, 8'h01, "rd_0000"};
        vecs[6] = '{1'b1, 14'h0100, 8'h5A, 8'h01, "wr_0100"};
        vecs[7] = '{1'b0, 14'h0100, 8'h00, 8'h5A, "rd_0100"};
        vecs[8] = '{1'b1, 14'h0200, 8'h33, 8'h5A, "wr_hold"};
        vecs[9] = '{1'b0, 14'h0200, 8'h00, 8'h33, "rd_0200"};

        // Reset is checked before any clock edge to show it acts asynchronously
        #1 reset = 1'b1;
        #1;
        checkOutput("rst ready", 32'(req_ready), 32'd1);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst resp_we", 32'(resp_we), 32'd0);
        checkOutput("rst rdata", 32'(resp_rdata), 32'd0);
        checkOutput("rst rdata_ext", 32'(resp_rdata_ext), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].name);
        end

        // Hold req_valid with a new address every cycle; only every third is taken
        bd_addr = '{14'h0010, 14'h0020, 14'h0100, 14'h3FFF, 14'h0010,
                    14'h0010, 14'h0000, 14'h0100, 14'h0200};
        pulses = 0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = bd_addr[i];
            @(negedge clk);
            if (resp_valid) pulses++;
            checkOutput($sformatf("busydrop valid %0d", i), 32'(resp_valid), 32'((i % 3) == 2));
            checkOutput($sformatf("busydrop ready %0d", i), 32'(req_ready), 32'((i % 3) == 2));
            if (i == 2) checkOutput("busydrop rdata0", 32'(resp_rdata), 32'h A5);
            if (i == 5) checkOutput("busydrop rdata1", 32'(resp_rdata), 32'h FF);
            if (i == 8) checkOutput("busydrop rdata2", 32'(resp_rdata), 32'h 01);
        end
        req_valid = 1'b0;
        checkOutput("busydrop pulses", 32'(pulses), 32'd3);

        applyStimulus(1'b1, 14'h0020, 8'h77, 8'h01, "wr_0020_prior");

        // Aborted write: reset lands in the last ACCESS cycle before completion
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 14'h0020;
        req_wdata = 8'h3C;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort ready", 32'(req_ready), 32'd1);
        checkOutput("abort resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("abort rdata", 32'(resp_rdata), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
            if (i == 2) reset = 1'b0;
        end
        checkOutput("abort pulses", 32'(pulses), 32'd0);
        applyStimulus(1'b0, 14'h0020, 8'h00, 8'h77, "rd_0020_after_abort");

        // LATENCY=1: even-cycle requests are taken, odd-cycle junk writes ignored
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            r1_valid = 1'b1;
            case (i)
                0: begin r1_we = 1'b1; r1_addr = 14'd5; r1_wdata = 8'h11; end
                2: begin r1_we = 1'b1; r1_addr = 14'd6; r1_wdata = 8'h22; end
                4: begin r1_we = 1'b0; r1_addr = 14'd5; r1_wdata = 8'h00; end
                6: begin r1_we = 1'b0; r1_addr = 14'd6; r1_wdata = 8'h00; end
                default: begin r1_we = 1'b1; r1_addr = 14'd5; r1_wdata = 8'hEE; end
            endcase
            @(negedge clk);
            checkOutput($sformatf("lat1 valid %0d", i), 32'(r1_resp_valid), 32'((i % 2) == 1));
            checkOutput($sformatf("lat1 ready %0d", i), 32'(r1_ready), 32'((i % 2) == 1));
            if ((i % 2) == 1) checkOutput($sformatf("lat1 resp_we %0d", i), 32'(r1_resp_we), 32'(i < 4));
            if (i == 5) checkOutput("lat1 rdata5", 32'(r1_rdata), 32'h11);
            if (i == 7) checkOutput("lat1 rdata6", 32'(r1_rdata_ext), 32'h22);
        end
        r1_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
